// File: rtl/stage_ex.sv
// Execute/complete stage: single-cycle ALU, 8-iteration nibble multiplier,
// and an in-order result FIFO whose head drives the CDB.
package sys_defs;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_AND,
    ALU_OR,  ALU_XOR, ALU_SLL, ALU_SRL,  ALU_SRA
  } ALU_FUNC;
endpackage

module stage_ex
  import sys_defs::*;
#(
  parameter int unsigned RESULT_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [31:0] issue_opA,
  input  logic [31:0] issue_opB,
  input  logic [4:0]  issue_tag,
  input  ALU_FUNC     issue_func,
  input  logic        issue_is_mult,
  input  logic        squash,
  input  logic        cdb_stall,
  output logic        issue_ready,
  output logic        rs_clear,
  output logic        cdb_valid,
  output logic [4:0]  cdb_tag,
  output logic [31:0] cdb_value,
  output logic [1:0]  ex_busy_debug
);
  localparam int unsigned PW = $clog2(RESULT_DEPTH);
  localparam logic [PW:0]   LP_DEPTH   = RESULT_DEPTH[PW:0];
  localparam logic [PW:0]   LP_CNT_ONE = 1;
  localparam logic [PW-1:0] LP_PTR_ONE = 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_HOLD = 2'd2} state_t;

  state_t        r_state;
  logic [31:0]   r_mcand;
  logic [31:0]   r_mplier;
  logic [31:0]   r_acc;
  logic [2:0]    r_iter;
  logic [4:0]    r_mtag;
  logic [4:0]    r_ftag [RESULT_DEPTH];
  logic [31:0]   r_fval [RESULT_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW:0]   r_count;

  logic        w_pop;
  logic        w_space;
  logic [31:0] w_alu;
  logic [3:0]  w_nib;
  logic [31:0] w_pp;
  logic [31:0] w_sum;
  logic        w_push;
  logic [4:0]  w_push_tag;
  logic [31:0] w_push_val;

  assign cdb_valid     = (r_count != '0);
  assign cdb_tag       = cdb_valid ? r_ftag[r_rd_ptr] : '0;
  assign cdb_value     = cdb_valid ? r_fval[r_rd_ptr] : '0;
  assign w_pop         = cdb_valid && !cdb_stall;
  assign w_space       = (r_count < LP_DEPTH) || w_pop;
  assign issue_ready   = !squash && (r_state == S_IDLE) && w_space;
  assign rs_clear      = issue_valid && issue_ready;
  assign ex_busy_debug = r_state;

  always_comb begin
    w_alu = '0;
    unique case (issue_func)
      ALU_ADD:  w_alu = issue_opA + issue_opB;
      ALU_SUB:  w_alu = issue_opA - issue_opB;
      ALU_SLT:  w_alu = {31'd0, $signed(issue_opA) < $signed(issue_opB)};
      ALU_SLTU: w_alu = {31'd0, issue_opA < issue_opB};
      ALU_AND:  w_alu = issue_opA & issue_opB;
      ALU_OR:   w_alu = issue_opA | issue_opB;
      ALU_XOR:  w_alu = issue_opA ^ issue_opB;
      ALU_SLL:  w_alu = issue_opA << issue_opB[4:0];
      ALU_SRL:  w_alu = issue_opA >> issue_opB[4:0];
      ALU_SRA:  w_alu = $unsigned($signed(issue_opA) >>> issue_opB[4:0]);
      default:  w_alu = '0;
    endcase
  end

  // One nibble of the multiplier per iteration, shifted into place.
  assign w_nib = r_mplier[{r_iter, 2'b00} +: 4];
  assign w_pp  = (r_mcand * {28'd0, w_nib}) << {r_iter, 2'b00};
  assign w_sum = r_acc + w_pp;

  always_comb begin
    w_push     = 1'b0;
    w_push_tag = '0;
    w_push_val = '0;
    if (!squash) begin
      if (rs_clear && !issue_is_mult) begin
        w_push     = 1'b1;
        w_push_tag = issue_tag;
        w_push_val = w_alu;
      end else if (r_state == S_MUL && r_iter == 3'd7 && w_space) begin
        w_push     = 1'b1;
        w_push_tag = r_mtag;
        w_push_val = w_sum;
      end else if (r_state == S_HOLD && w_space) begin
        w_push     = 1'b1;
        w_push_tag = r_mtag;
        w_push_val = r_acc;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_iter   <= '0;
      r_mtag   <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < RESULT_DEPTH; i++) begin
        r_ftag[i] <= '0;
        r_fval[i] <= '0;
      end
    end else if (squash) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_iter   <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (rs_clear && issue_is_mult) begin
          r_mcand  <= issue_opA;
          r_mplier <= issue_opB;
          r_mtag   <= issue_tag;
          r_acc    <= '0;
          r_iter   <= '0;
          r_state  <= S_MUL;
        end
        S_MUL: begin
          r_iter <= r_iter + 3'd1;
          if (r_iter == 3'd7) begin
            r_acc   <= w_sum;
            r_state <= w_space ? S_IDLE : S_HOLD;
          end else begin
            r_acc <= w_sum;
          end
        end
        S_HOLD: if (w_space) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_push) begin
        r_ftag[r_wr_ptr] <= w_push_tag;
        r_fval[r_wr_ptr] <= w_push_val;
        r_wr_ptr         <= r_wr_ptr + LP_PTR_ONE;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LP_CNT_ONE;
        2'b01:   r_count <= r_count - LP_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule
